// File: rtl/dma_channel_ctrl.sv
// Single-channel DMA controller: register-programmed MEM2MEM, IO2MEM and MEM2IO word moves.
// Build option: define DMA_AUTOINIT_EN to honour mode[4] (auto-reinitialise at terminal count).
module dma_channel_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_wr,
    input  logic [15:0]       Address_bus,
    input  logic [DATA_W-1:0] data_bus,
    output logic [15:0]       mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              io_dreq,
    output logic              io_dack,
    input  logic [DATA_W-1:0] io_rdata,
    output logic [DATA_W-1:0] io_wdata,
    output logic              busy,
    output logic              tc
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;
    typedef enum logic [1:0] {X_NONE, X_M2M, X_IO2MEM, X_MEM2IO} xfer_t;

    state_t            state;
    xfer_t             xfer;
    xfer_t             start_type;
    logic [15:0]       src_reg, dst_reg, cnt_reg;
    logic              cmd_m2m, mode_io2mem, mode_mem2io, mask_bit;
`ifdef DMA_AUTOINIT_EN
    logic              mode_auto;
`endif
    logic [15:0]       w_src, w_dst, w_cnt;
    logic [DATA_W-1:0] data_lat;
    logic [3:0]        reg_sel;
    logic              unused_addr;
    logic              start, abort, wr_done;

    function automatic xfer_t decode_type(input logic m2m, input logic io2mem, input logic mem2io);
        if (m2m)         return X_M2M;
        else if (io2mem) return X_IO2MEM;
        else if (mem2io) return X_MEM2IO;
        else             return X_NONE;
    endfunction

    assign reg_sel     = Address_bus[3:0];
    assign unused_addr = ^Address_bus[15:4];
    assign start_type  = decode_type(cmd_m2m, mode_io2mem, mode_mem2io);
    assign start   = reg_wr && (reg_sel == 4'd12) && (state == S_IDLE) && !mask_bit
                     && (start_type != X_NONE);
    assign abort   = reg_wr && (reg_sel == 4'd11) && data_bus[0] && (state != S_IDLE);
    // MEM2IO finishes its write on the peripheral handshake, the others on mem_ack.
    assign wr_done = (state == S_WR) && ((xfer == X_MEM2IO) ? io_dreq : (mem_wr && mem_ack));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            xfer        <= X_NONE;
            src_reg     <= '0;
            dst_reg     <= '0;
            cnt_reg     <= '0;
            cmd_m2m     <= 1'b0;
            mode_io2mem <= 1'b0;
            mode_mem2io <= 1'b0;
`ifdef DMA_AUTOINIT_EN
            mode_auto   <= 1'b0;
`endif
            mask_bit    <= 1'b1;
            w_src       <= '0;
            w_dst       <= '0;
            w_cnt       <= '0;
            data_lat    <= '0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_wdata   <= '0;
            io_dack     <= 1'b0;
            io_wdata    <= '0;
            busy        <= 1'b0;
            tc          <= 1'b0;
        end else begin
            io_dack <= 1'b0;
            tc      <= 1'b0;
            if (reg_wr) begin
                case (reg_sel)
                    4'd0:  src_reg <= data_bus[15:0];
                    4'd1:  cnt_reg <= data_bus[15:0];
                    4'd7:  cmd_m2m <= data_bus[0];
                    4'd10: begin
                        mode_mem2io <= data_bus[2];
                        mode_io2mem <= data_bus[3];
`ifdef DMA_AUTOINIT_EN
                        mode_auto   <= data_bus[4];
`endif
                    end
                    4'd11: mask_bit <= data_bus[0];
                    4'd13: dst_reg  <= data_bus[15:0];
                    default: ;
                endcase
            end

            if (abort) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                mem_rd  <= 1'b0;
                mem_wr  <= 1'b0;
                io_dack <= 1'b0;
                tc      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            w_src <= src_reg;
                            w_dst <= dst_reg;
                            w_cnt <= cnt_reg;
                            xfer  <= start_type;
                            busy  <= 1'b1;
                            state <= S_RD;
                        end
                    end
                    S_RD: begin
                        if (xfer == X_IO2MEM) begin
                            if (io_dreq) begin
                                io_dack  <= 1'b1;
                                data_lat <= io_rdata;
                                state    <= S_WR;
                            end
                        end else if (!mem_rd) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= w_src;
                        end else if (mem_ack) begin
                            mem_rd   <= 1'b0;
                            data_lat <= mem_rdata;
                            state    <= S_WR;
                        end
                    end
                    S_WR: begin
                        if ((xfer != X_MEM2IO) && !mem_wr) begin
                            mem_wr    <= 1'b1;
                            mem_addr  <= (xfer == X_M2M) ? w_dst : w_src;
                            mem_wdata <= data_lat;
                        end
                        if (wr_done) begin
                            mem_wr <= 1'b0;
                            if (xfer == X_MEM2IO) begin
                                io_dack  <= 1'b1;
                                io_wdata <= data_lat;
                            end
                            w_src <= w_src + 16'd1;
                            w_dst <= w_dst + 16'd1;
                            // count is "words minus one": zero here means this was the last word
                            if (w_cnt == 16'd0) begin
                                tc    <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                w_cnt <= w_cnt - 16'd1;
                                state <= S_RD;
                            end
                        end
                    end
                    S_DONE: begin
`ifdef DMA_AUTOINIT_EN
                        if (mode_auto) begin
                            w_src <= src_reg;
                            w_dst <= dst_reg;
                            w_cnt <= cnt_reg;
                            state <= S_RD;
                        end else begin
                            mask_bit <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
`else
                        mask_bit <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
`endif
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_channel_ctrl.sv
// Bench for dma_channel_ctrl: expected bus-event sequences per transfer plus literal pins.
module tb_dma_channel_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr = 1'b0;
    logic [15:0] Address_bus = '0;
    logic [15:0] data_bus = '0;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        io_dreq = 1'b0;
    logic        io_dack;
    logic [15:0] io_rdata = 16'h3C00;
    logic [15:0] io_wdata;
    logic        busy, tc;

    dma_channel_ctrl dut (
        .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .Address_bus(Address_bus),
        .data_bus(data_bus), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .io_dreq(io_dreq), .io_dack(io_dack), .io_rdata(io_rdata), .io_wdata(io_wdata),
        .busy(busy), .tc(tc)
    );

    always #5 clk = ~clk;

    // event kinds: 0 mem read, 1 mem write, 2 io_dack, 3 tc
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        bit          chk;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          free_run = 1'b0;
    int          tc_free = 0;
    int          n_rd = 0, n_wr = 0, n_dack = 0, n_tc = 0;
    int          io_seq = 0;
    logic [15:0] last_wdata = '0;
    logic [15:0] last_iowdata = '0;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void push(input int k, input logic [15:0] a, input logic [15:0] d, input bit c);
        exp_q.push_back('{kind: k, addr: a, data: d, chk: c});
    endfunction

    // Model: a transfer of count+1 words as a flat list of bus events, then one tc.
    // ty 0 MEM2MEM, 1 IO2MEM, 2 MEM2IO; io_base = index of the next io_dack overall.
    task automatic plan(input int ty, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] c, input int io_base);
        logic [15:0] sa, da;
        for (int i = 0; i <= int'(c); i++) begin
            sa = s + 16'(i);
            da = d + 16'(i);
            case (ty)
                0: begin push(0, sa, 16'h0, 1'b0); push(1, da, memfn(sa), 1'b1); end
                1: begin push(2, 16'h0, 16'h0, 1'b0); push(1, sa, 16'h3C00 + 16'(io_base + i), 1'b1); end
                default: begin push(0, sa, 16'h0, 1'b0); push(2, 16'h0, memfn(sa), 1'b1); end
            endcase
        end
        push(3, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic note(input int kind, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        case (kind)
            0: n_rd++;
            1: begin n_wr++; last_wdata = d; end
            2: begin n_dack++; last_iowdata = d; end
            default: n_tc++;
        endcase
        if (free_run) begin
            if (kind == 3) tc_free++;
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d addr=%h data=%h required=none", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (e.kind <= 1 && e.addr != a) || (e.chk && e.data != d)) begin
                errors++;
                $display("FAIL bus_event actual kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // memory and peripheral responder: one-cycle ack latency, io data advances per dack
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (io_dack) begin
                io_seq++;
                io_rdata = 16'h3C00 + 16'(io_seq);
            end
            if ((mem_rd || mem_wr) && !mem_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = memfn(mem_addr);
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // compare process
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("strobe_exclusive", int'(mem_rd) + int'(mem_wr) + int'(io_dack) <= 1, 1);
                if (mem_rd && mem_ack) note(0, mem_addr, 16'h0);
                if (mem_wr && mem_ack) note(1, mem_addr, mem_wdata);
                if (io_dack)           note(2, 16'h0, io_wdata);
                if (tc)                note(3, 16'h0, 16'h0);
            end
        end
    end

    task automatic wr_now(input logic [15:0] a, input logic [15:0] d);
        reg_wr      = 1'b1;
        Address_bus = a;
        data_bus    = d;
        @(negedge clk);
        reg_wr      = 1'b0;
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_now(a, d);
    endtask

    task automatic wait_q(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_sig(input string name, input bit want_wr);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = want_wr ? mem_wr : mem_rd;
        end
        check(name, seen, 1);
    endtask

    initial begin
        int b_rd, b_wr, b_dk, b_tc;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_strobes", {mem_rd, mem_wr, io_dack, tc}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wdata", {mem_wdata, io_wdata}, 0);
        rst_n = 1'b1;
        io_dreq = 1'b1;

        // masked at reset: request dropped
        wr_reg(16'hA007, 16'h0001);
        wr_reg(16'h0000, 16'h0100);
        wr_reg(16'h000D, 16'h0200);
        wr_reg(16'h0001, 16'h0002);
        wr_reg(16'h000C, 16'h0000);
        repeat (20) @(negedge clk);
        check("masked_req_busy", busy, 0);
        check("masked_req_rd", n_rd, 0);

        // MEM2MEM, plus a second request while busy
        wr_reg(16'h000B, 16'h0000);
        b_rd = n_rd; b_wr = n_wr; b_tc = n_tc;
        plan(0, 16'h0100, 16'h0200, 16'd2, io_seq);
        wr_reg(16'h000C, 16'h0000);
        repeat (3) @(negedge clk);
        check("m2m_busy", busy, 1);
        wr_now(16'h000C, 16'h0000);
        check("m2m_busy_after_req2", busy, 1);
        wait_q("m2m_done");
        repeat (3) @(negedge clk);
        check("m2m_idle", busy, 0);
        check("m2m_reads", n_rd - b_rd, 3);
        check("m2m_writes", n_wr - b_wr, 3);
        check("m2m_tc", n_tc - b_tc, 1);
        check("m2m_last_wdata", last_wdata, 16'h5B58);

        // mask[0] now set by completion
        wr_reg(16'h000C, 16'h0000);
        repeat (20) @(negedge clk);
        check("m2m_remask", busy, 0);

        // IO2MEM single word
        wr_reg(16'h0007, 16'h0000);
        wr_reg(16'h000A, 16'h0008);
        wr_reg(16'h0000, 16'h0010);
        wr_reg(16'h0001, 16'h0000);
        wr_reg(16'h000B, 16'h0000);
        b_dk = n_dack; b_tc = n_tc;
        plan(1, 16'h0010, 16'h0000, 16'd0, io_seq);
        wr_reg(16'h000C, 16'h0000);
        wait_q("io2mem_done");
        repeat (3) @(negedge clk);
        check("io2mem_dack", n_dack - b_dk, 1);
        check("io2mem_tc", n_tc - b_tc, 1);
        check("io2mem_wdata", last_wdata, 16'h3C00);

        // MEM2IO with address wrap
        wr_reg(16'h000A, 16'h0004);
        wr_reg(16'h0000, 16'hFFFF);
        wr_reg(16'h0001, 16'h0001);
        wr_reg(16'h000B, 16'h0000);
        b_dk = n_dack;
        plan(2, 16'hFFFF, 16'h0000, 16'd1, io_seq);
        wr_reg(16'h000C, 16'h0000);
        wait_q("mem2io_done");
        repeat (3) @(negedge clk);
        check("mem2io_dack", n_dack - b_dk, 2);
        check("mem2io_last_iowdata", last_iowdata, 16'h5A5A);

        // abort by mask write during WR, then reset during RD of a new transfer
        free_run = 1'b1;
        wr_reg(16'h0007, 16'h0001);
        wr_reg(16'h0000, 16'h0300);
        wr_reg(16'h000D, 16'h0400);
        wr_reg(16'h0001, 16'h0005);
        wr_reg(16'h000B, 16'h0000);
        wr_reg(16'h000C, 16'h0000);
        wait_sig("abort_reach_wr", 1'b1);
        wr_now(16'h000B, 16'h0001);
        check("abort_busy", busy, 0);
        check("abort_strobes", {mem_rd, mem_wr, io_dack}, 0);
        repeat (10) @(negedge clk);
        check("abort_quiet", {busy, mem_rd, mem_wr}, 0);
        wr_reg(16'h0000, 16'h0500);
        wr_reg(16'h000B, 16'h0000);
        wr_reg(16'h000C, 16'h0000);
        wait_sig("rst_reach_rd", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {busy, mem_rd, mem_wr, io_dack, tc}, 0);
        check("midrst_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_tc", tc_free, 0);
        check("post_rst_idle", busy, 0);
        free_run = 1'b0;

        // mode[4] set alongside IO2MEM
        wr_reg(16'h000A, 16'h0018);
        wr_reg(16'h0000, 16'h0020);
        wr_reg(16'h0001, 16'h0000);
        wr_reg(16'h000B, 16'h0000);
        b_tc = n_tc;
`ifdef DMA_AUTOINIT_EN
        for (int r = 0; r < 3; r++) plan(1, 16'h0020, 16'h0000, 16'd0, io_seq + r);
        wr_reg(16'h000C, 16'h0000);
        wait_q("auto_done");
        check("auto_busy", busy, 1);
        check("auto_tc", n_tc - b_tc, 3);
        free_run = 1'b1;
        tc_free = 0;
        wr_reg(16'h000B, 16'h0001);
        repeat (10) @(negedge clk);
        check("auto_stop", busy, 0);
        check("auto_stop_tc", tc_free, 0);
        free_run = 1'b0;
`else
        plan(1, 16'h0020, 16'h0000, 16'd0, io_seq);
        wr_reg(16'h000C, 16'h0000);
        wait_q("noauto_done");
        repeat (20) @(negedge clk);
        check("noauto_idle", busy, 0);
        check("noauto_tc", n_tc - b_tc, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_channel_ctrl.md
DMA_CHANNEL_CTRL -- requirements
Module: dma_channel_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all ports are listed below, clock and reset first.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reg_wr  input  1  register write strobe; one write per high cycle.
REQ-005 Address_bus  input  16  register address; only [3:0] decoded, [15:4] ignored.
REQ-006 data_bus  input  16  register write data.
REQ-007 mem_addr  output  16  memory word address.
REQ-008 mem_rd / mem_wr  output  1 each  memory read / write request, held until mem_ack.
REQ-009 mem_wdata  output  16 / mem_rdata  input  16  memory write data / read data, rdata valid with mem_ack.
REQ-010 mem_ack  input  1  memory handshake completion.
REQ-011 io_dreq  input  1 / io_dack  output  1  peripheral request / one-cycle acknowledge.
REQ-012 io_rdata  input  16 / io_wdata  output  16  peripheral data in / out.
REQ-013 busy  output  1 / tc  output  1  transfer active / one-cycle terminal-count pulse.

Function
REQ-014 Program registers SHALL be: 0 src base, 1 word count, 7 command, 10 mode, 11 mask, 12 request (write-only trigger), 13 dest base; writes to other addresses SHALL be ignored.
REQ-015 A request write SHALL start a transfer only if state is IDLE and mask[0]=0; otherwise it is dropped.
REQ-016 Transfer type at start: command[0]=1 -> MEM2MEM; else mode[3]=1 -> IO2MEM; else mode[2]=1 -> MEM2IO; none set -> no start.
REQ-017 Start SHALL copy src, dest, count into working registers; later program writes SHALL NOT affect the running transfer.
REQ-018 FSM states SHALL be IDLE, RD, WR, DONE; start moves IDLE->RD next cycle with busy=1.
REQ-019 RD: MEM2MEM/MEM2IO assert mem_rd at working src until mem_ack, latching mem_rdata; IO2MEM waits io_dreq, pulses io_dack one cycle, latches io_rdata.
REQ-020 WR: MEM2MEM assert mem_wr at working dest; IO2MEM assert mem_wr at working src; MEM2IO waits io_dreq, pulses io_dack with io_wdata = latched word.
REQ-021 After WR completes, working addresses SHALL increment by 1 (wrapping 0xFFFF->0x0000) and count decrement; count 0 before decrement -> DONE, else RD.
REQ-022 Transfers SHALL move count+1 words (count 0 = one word, 0xFFFF = 65536 words).
REQ-023 DONE SHALL assert tc for exactly one cycle, set mask[0]=1, return to IDLE; busy low from the IDLE cycle.
REQ-024 A mask write with bit0=1 while busy SHALL abort: strobes drop next cycle, state -> IDLE, no tc.
REQ-025 mem_rd, mem_wr, io_dack SHALL never be high simultaneously; all outputs registered.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, all registers 0 except mask=0x0001, all outputs 0.
REQ-027 Reset mid-transfer SHALL abandon the transfer with no tc pulse.

Configuration
REQ-028 With DMA_AUTOINIT_EN defined, mode[4]=1 SHALL at DONE pulse tc, reload working registers from program registers, leave mask[0]=0, and go to RD.
REQ-029 Without DMA_AUTOINIT_EN, mode[4] SHALL be ignored and REQ-023 applies.

Verification
REQ-030 MEM2MEM: src=0x0100, dest=0x0200, count=2, command=1, mask=0, request -> 3 reads 0x0100-0x0102, 3 writes 0x0200-0x0202, one tc, mask[0]=1.
REQ-031 IO2MEM: mode=0x0008, src=0x0010, count=0, io_dreq high -> one io_dack, mem_wr at 0x0010 with io_rdata, tc.
REQ-032 MEM2IO: mode=0x0004, src=0xFFFF, count=1 -> reads 0xFFFF then 0x0000 (wrap), two io_dack pulses with matching io_wdata.
REQ-033 Request with mask=0x0001, or second request while busy -> no bus activity / no restart, busy unchanged.
REQ-034 Mask=0x0001 written during WR, then rst_n low mid-RD on a new transfer -> abort to IDLE, outputs 0, no tc either time.
REQ-035 DMA_AUTOINIT_EN, mode=0x0018, count=0 -> tc every transfer, transfer repeats from src, mask[0] stays 0.
